wb_writer: RTL and testbench

Writeback-side writer for the pipeline register file. It accepts completed results from the ALU and the load/store unit (LSU) through valid/ready handshakes and buffers them in a small in-order FIFO. It drives the register file's single write port (`we3`/`wa3`/`wd3`) at one write per cycle. It also keeps a pending-write scoreboard so the decode stage can detect read-after-write hazards on registers whose results have not yet been written.

---
 rtl/wb_writer_pkg.sv | 12 +
 rtl/wb_fifo.sv | 48 ++++
 rtl/wb_writer.sv | 81 ++++++++
 tb/tb_wb_writer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_writer_pkg.sv
// Shared types and constants for the writeback writer.
package wb_writer_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RegAw = 5;

  typedef struct packed {
    logic [RegAw-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO with two write ports (port 0 is older) and one read port.
// Head reads zero when empty so downstream sees a clean idle write port.
module wb_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 37
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push0_i,
  input  logic [Width-1:0]         data0_i,
  input  logic                     push1_i,
  input  logic [Width-1:0]         data1_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         head_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rptr_q, wptr_q, wptr_inc;
  logic [PtrW:0]    cnt_q, cnt_d;

  assign wptr_inc = wptr_q + PtrW'(1);
  assign cnt_d    = cnt_q + (PtrW + 1)'(push0_i) + (PtrW + 1)'(push1_i) - (PtrW + 1)'(pop_i);

  // Storage needs no reset: the head is gated by the count.
  always_ff @(posedge clk_i) begin
    if (push0_i) mem_q[wptr_q] <= data0_i;
    if (push1_i) mem_q[push0_i ? wptr_inc : wptr_q] <= data1_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + PtrW'(push0_i) + PtrW'(push1_i);
      if (pop_i) rptr_q <= rptr_q + PtrW'(1);
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = (cnt_q != '0) ? mem_q[rptr_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/wb_writer.sv
// Writeback writer: arbitrates ALU/LSU results into a FIFO that drains one
// register-file write per cycle, and tracks outstanding writes for decode.
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             lsu_valid,
  input  logic [4:0]       lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  output logic             lsu_ready,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  output logic             we3,
  output logic [4:0]       wa3,
  output logic [XLEN-1:0]  wd3,
  output logic [31:0]      pend
);

  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned EntryW = RegAw + XLEN;

  logic [CntW-1:0]   count, free;
  logic              lsu_push, alu_push;
  logic [EntryW-1:0] head;
  logic [31:0]       pend_q, pend_d;

  // ALU needs two free slots so an LSU result on the same edge always fits.
  assign free      = CntW'(DEPTH) - count;
  assign lsu_ready = (free >= CntW'(1));
  assign alu_ready = (free >= CntW'(2));

  // x0 results complete the handshake but are dropped.
  assign lsu_push = lsu_valid & lsu_ready & (lsu_rd != '0);
  assign alu_push = alu_valid & alu_ready & (alu_rd != '0);

  wb_fifo #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push0_i (lsu_push),
    .data0_i ({lsu_rd, lsu_data}),
    .push1_i (alu_push),
    .data1_i ({alu_rd, alu_data}),
    .pop_i   (we3),
    .head_o  (head),
    .count_o (count)
  );

  assign we3 = (count != '0);
  assign wa3 = head[XLEN +: RegAw];
  assign wd3 = head[XLEN-1:0];

  // Set after clear so a reissue on the retiring edge keeps the bit pending.
  always_comb begin
    pend_d = pend_q;
    if (we3) pend_d[wa3] = 1'b0;
    if (issue_valid && (issue_rd != '0)) pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer with a queue-based reference model.
module tb_wb_writer;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, lsu_valid, issue_valid;
  logic [4:0]      alu_rd, lsu_rd, issue_rd;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic            alu_ready, lsu_ready;
  logic            we3;
  logic [4:0]      wa3;
  logic [XLEN-1:0] wd3;
  logic [31:0]     pend;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [4:0]      m_rd[$];
  logic [XLEN-1:0] m_data[$];
  logic [31:0]     m_pend;

  wb_writer #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .lsu_valid   (lsu_valid),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_ready   (lsu_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .we3         (we3),
    .wa3         (wa3),
    .wd3         (wd3),
    .pend        (pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rd.delete();
    m_data.delete();
    m_pend = '0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge occupancy.
  task automatic model_update();
    int  sz;
    bit  lr, ar;
    logic [4:0] prd;
    sz = m_rd.size();
    lr = (sz < DEPTH);
    ar = (sz <= DEPTH - 2);
    if (sz > 0) begin
      prd = m_rd.pop_front();
      void'(m_data.pop_front());
      m_pend[prd] = 1'b0;
    end
    if (lsu_valid && lr && lsu_rd != 0) begin
      m_rd.push_back(lsu_rd);
      m_data.push_back(lsu_data);
    end
    if (alu_valid && ar && alu_rd != 0) begin
      m_rd.push_back(alu_rd);
      m_data.push_back(alu_data);
    end
    if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    m_pend[0] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic drive(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic iv, input logic [4:0] ird);
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    issue_valid = iv; issue_rd = ird;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("cyc_we3", 64'(we3), 64'(m_rd.size() != 0));
        check("cyc_wa3", 64'(wa3), 64'((m_rd.size() != 0) ? m_rd[0] : 5'd0));
        check("cyc_wd3", 64'(wd3), 64'((m_rd.size() != 0) ? m_data[0] : 32'd0));
        check("cyc_lsu_ready", 64'(lsu_ready), 64'(m_rd.size() < DEPTH));
        check("cyc_alu_ready", 64'(alu_ready), 64'(m_rd.size() <= DEPTH - 2));
        check("cyc_pend", 64'(pend), 64'(m_pend));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    #12;
    check("rst_we3", 64'(we3), 64'd0);
    check("rst_wa3", 64'(wa3), 64'd0);
    check("rst_wd3", 64'(wd3), 64'd0);
    check("rst_pend", 64'(pend), 64'd0);
    check("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();

    // Single ALU result
    drive(0, 0, 0, 0, 0, 0, 1, 5);
    step();
    drive(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    step();
    idle();
    check("t1_we3", 64'(we3), 64'd1);
    check("t1_wa3", 64'(wa3), 64'd5);
    check("t1_wd3", 64'(wd3), 64'hDEADBEEF);
    check("t1_pend_set", 64'(pend[5]), 64'd1);
    step();
    check("t1_we3_off", 64'(we3), 64'd0);
    check("t1_pend_clr", 64'(pend), 64'd0);

    // Same-edge LSU then ALU
    drive(0, 0, 0, 0, 0, 0, 1, 3);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 4);
    step();
    drive(1, 3, 32'h11, 1, 4, 32'h22, 0, 0);
    step();
    idle();
    check("t2_first_wa3", 64'(wa3), 64'd3);
    check("t2_first_wd3", 64'(wd3), 64'h11);
    step();
    check("t2_second_we3", 64'(we3), 64'd1);
    check("t2_second_wa3", 64'(wa3), 64'd4);
    check("t2_second_wd3", 64'(wd3), 64'h22);
    step();
    check("t2_drained", 64'(we3), 64'd0);

    // Two pushes per cycle until occupancy saturates at DEPTH-1
    drive(1, 8, 32'h108, 1, 16, 32'h210, 0, 0);
    step();
    drive(1, 9, 32'h109, 1, 17, 32'h211, 0, 0);
    step();
    check("t3_cnt3_alu_ready", 64'(alu_ready), 64'd0);
    check("t3_cnt3_lsu_ready", 64'(lsu_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      drive(1, 5'(10 + c), 32'h10A + c, 1, 5'(18 + c), 32'h212 + c, 0, 0);
      step();
    end
    idle();
    repeat (5) step();
    check("t3_drained", 64'(we3), 64'd0);

    // x0 result is accepted but never written
    check("t4_alu_ready", 64'(alu_ready), 64'd1);
    drive(0, 0, 0, 1, 0, 32'h55, 0, 0);
    step();
    idle();
    check("t4_no_we3", 64'(we3), 64'd0);
    check("t4_wd3_zero", 64'(wd3), 64'd0);
    step();
    check("t4_no_we3_later", 64'(we3), 64'd0);

    // Reissue on the retiring edge keeps the pending bit
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    step();
    idle();
    check("t5_pend_n1", 64'(pend[7]), 64'd1);
    step();
    check("t5_pend_n2", 64'(pend[7]), 64'd1);
    drive(0, 0, 0, 1, 7, 32'h77, 0, 0);
    step();
    idle();
    check("t5_pend_n3", 64'(pend[7]), 64'd1);
    check("t5_wa3", 64'(wa3), 64'd7);
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    step();
    idle();
    check("t5_pend_n4", 64'(pend[7]), 64'd1);
    check("t5_we3_off", 64'(we3), 64'd0);
    step();
    check("t5_pend_hold", 64'(pend[7]), 64'd1);

    // Reset with three entries queued
    drive(0, 0, 0, 0, 0, 0, 1, 9);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 10);
    step();
    drive(1, 9, 32'h99, 1, 10, 32'hAA, 0, 0);
    step();
    drive(1, 11, 32'hBB, 1, 12, 32'hCC, 0, 0);
    step();
    idle();
    check("t6_queued_we3", 64'(we3), 64'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_we3", 64'(we3), 64'd0);
    check("t6_rst_pend", 64'(pend), 64'd0);
    step();
    rst_n = 1'b1;
    check("t6_rel_lsu_ready", 64'(lsu_ready), 64'd1);
    check("t6_rel_alu_ready", 64'(alu_ready), 64'd1);
    step();
    check("t6_rel_we3", 64'(we3), 64'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
